interval_timer: RTL and testbench
=================================

Name: interval_timer

Overview:
- Down-counting interval timer with reload, one-shot and periodic modes, and a clock prescaler.
- Complements the up-counting counter: software/FSM logic loads an interval, and the block signals expiry.
- Used for sample-window gating, timeouts and periodic measurement triggers in the receiver datapath.

Parameters:
MAX_LOAD, 1000, largest legal interval in ticks; count width W = $clog2(MAX_LOAD+1)
PRESCALE, 1, clk cycles per tick (>=1); prescaler width PW = max(1,$clog2(PRESCALE))

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start_i  input  1  load interval and (re)start timer
stop_i  input  1  abort timer, return to idle
periodic_i  input  1  mode select, sampled only on accepted start: 1=periodic, 0=one-shot
load_val_i  input  W  interval in ticks, sampled on accepted start
count_o  output  W  remaining ticks
busy_o  output  1  high while in RUN
expired_o  output  1  one-cycle pulse when interval elapses
err_o  output  1  one-cycle pulse when start is rejected (load_val_i==0)

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst.
- Reset values: state IDLE, count_o=0, busy_o=0, expired_o=0, err_o=0, reload reg=0, mode reg=0, prescaler=0.
- Priority, highest first: rst > stop_i > start_i > tick-driven decrement/expiry.
- States are IDLE and RUN. busy_o = (state==RUN), registered.
- Start accepted (any state, stop_i low, load_val_i != 0):
  - reload <= min(load_val_i, MAX_LOAD); count_o <= same value.
  - mode <= periodic_i; prescaler cleared; state <= RUN.
  - Start while in RUN retriggers with the new value, with no expiry pulse.
- Start with load_val_i==0: err_o pulses the next cycle; state, count and mode are unchanged.
- stop_i: state <= IDLE, count_o <= 0, prescaler cleared, no expired_o. stop_i in IDLE only forces count_o to 0.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN.
  - tick = (prescaler==PRESCALE-1); wraps to 0 on tick.
  - PRESCALE=1 gives tick every RUN cycle.
- On tick in RUN with count_o>1: count_o decrements by 1.
- On tick in RUN with count_o==1:
  - expired_o <= 1 for exactly one cycle.
  - One-shot: count_o <= 0, state <= IDLE.
  - Periodic: count_o <= reload, stay RUN, prescaler keeps running, so no gap between periods.
- Latency: start accepted at edge 0 with value N → expired_o high in the cycle after edge N*PRESCALE.
  - Periodic mode repeats every N*PRESCALE cycles exactly.
- Simultaneous events:
  - start and expiry in the same cycle: start wins, no pulse.
  - stop and expiry in the same cycle: stop wins, no pulse.
  - rst mid-RUN: all state returns to reset values at that edge.
- Arithmetic: unsigned W-bit. Values above MAX_LOAD clamp to MAX_LOAD. count_o never underflows or wraps below 0.
- expired_o and err_o are never high for two consecutive cycles from a single event.

Decomposition:
- timer_pkg holds:
  - timer_state_t enum {IDLE, RUN}
  - mode constants MODE_ONESHOT=0, MODE_PERIODIC=1
- One sub-module, tick_prescaler (clk, rst, clr_i, en_i, tick_o; param PRESCALE), instantiated once.
- Counting/FSM logic lives in interval_timer.

Test Plan:
- Reset: hold rst 3 cycles mid-RUN (N=10) → next cycle count_o=0, busy_o=0, expired_o=0; no pulse afterward.
- One-shot: PRESCALE=1, start N=5, periodic_i=0 → count_o 5,4,3,2,1,0; expired_o high exactly cycle 6 after start; busy_o low from then.
- Periodic with prescale: PRESCALE=4, start N=3, periodic_i=1 → expired_o pulses at cycles 13, 25, 37 after start; count_o reloads to 3 each time.
- Retrigger and stop: start N=8, at count_o=2 start N=4 → count_o=4, no pulse, expiry 4 ticks later. Then stop_i asserted together with expiry tick → no pulse, IDLE, count_o=0.
- Boundaries:
  - start with load_val_i=0 → err_o one-cycle pulse, state unchanged.
  - load_val_i=MAX_LOAD+5 (where it fits W) → count_o=MAX_LOAD.
  - N=1, PRESCALE=1 → expired_o the cycle after the first RUN edge.
- Start/expiry collision: periodic N=2, assert start_i N=6 on the expiry tick cycle → no expired_o, count_o=6, mode taken from periodic_i at that edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer slice.
package timer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one tick every PRESCALE enabled cycles; clr_i restarts the phase.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_r;

  assign tick_o = en_i && (cnt_r == LAST);

  // Phase counter: wraps on tick so consecutive periods have no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {PW{1'b0}};
    end else if (clr_i) begin
      cnt_r <= {PW{1'b0}};
    end else if (en_i) begin
      if (cnt_r == LAST) begin
        cnt_r <= {PW{1'b0}};
      end else begin
        cnt_r <= cnt_r + PW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Down-counting interval timer with one-shot/periodic modes and a tick prescaler.
module interval_timer
  import timer_pkg::*;
#(
  parameter int MAX_LOAD = 1000,
  parameter int PRESCALE = 1,
  localparam int W = $clog2(MAX_LOAD + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         periodic_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         busy_o,
  output logic         expired_o,
  output logic         err_o
);

  localparam logic [W-1:0] MAX_W = W'(MAX_LOAD);
  localparam logic [W-1:0] ONE_W = W'(1);

  timer_state_t state_r;
  logic [W-1:0] reload_r;
  logic         mode_r;
  logic         start_ok_s;
  logic         start_bad_s;
  logic         presc_clr_s;
  logic         tick_s;
  logic [W-1:0] clamp_s;

  assign start_ok_s  = start_i && !stop_i && (load_val_i != {W{1'b0}});
  assign start_bad_s = start_i && !stop_i && (load_val_i == {W{1'b0}});
  assign presc_clr_s = stop_i || start_ok_s;
  assign clamp_s     = (load_val_i > MAX_W) ? MAX_W : load_val_i;
  assign busy_o      = (state_r == RUN);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (presc_clr_s),
    .en_i   (busy_o),
    .tick_o (tick_s)
  );

  // Control FSM and counter: stop beats start, start beats the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      count_o   <= {W{1'b0}};
      reload_r  <= {W{1'b0}};
      mode_r    <= MODE_ONESHOT;
      expired_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      expired_o <= 1'b0;
      err_o     <= start_bad_s;
      if (stop_i) begin
        state_r <= IDLE;
        count_o <= {W{1'b0}};
      end else if (start_ok_s) begin
        reload_r <= clamp_s;
        count_o  <= clamp_s;
        mode_r   <= periodic_i;
        state_r  <= RUN;
      end else begin
        case (state_r)
          RUN: begin
            if (tick_s && (count_o > ONE_W)) begin
              count_o <= count_o - ONE_W;
            end else if (tick_s && (count_o == ONE_W)) begin
              expired_o <= 1'b1;
              if (mode_r == MODE_PERIODIC) begin
                count_o <= reload_r;
              end else begin
                count_o <= {W{1'b0}};
                state_r <= IDLE;
              end
            end else begin
              count_o <= count_o;
            end
          end
          IDLE: begin
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            count_o <= {W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench: one timer at PRESCALE=1 (dut "a") and one at PRESCALE=4 (dut "b").
module tb_interval_timer;

  localparam int W = $clog2(1000 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_start = 1'b0, a_stop = 1'b0, a_per = 1'b0;
  logic [W-1:0] a_load = '0;
  logic [W-1:0] a_count;
  logic a_busy, a_exp, a_err;
  logic b_start = 1'b0, b_stop = 1'b0, b_per = 1'b0;
  logic [W-1:0] b_load = '0;
  logic [W-1:0] b_count;
  logic b_busy, b_exp, b_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  interval_timer #(.MAX_LOAD(1000), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .stop_i(a_stop), .periodic_i(a_per),
    .load_val_i(a_load), .count_o(a_count), .busy_o(a_busy), .expired_o(a_exp), .err_o(a_err)
  );

  interval_timer #(.MAX_LOAD(1000), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .stop_i(b_stop), .periodic_i(b_per),
    .load_val_i(b_load), .count_o(b_count), .busy_o(b_busy), .expired_o(b_exp), .err_o(b_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input int n, input logic per);
    a_start = 1'b1; a_load = W'(n); a_per = per;
    step();
    a_start = 1'b0;
  endtask

  task automatic test_reset;
    step(); step();
    rst = 1'b0;
    total++;
    if (a_count !== '0 || a_busy !== 1'b0 || a_exp !== 1'b0 || a_err !== 1'b0) begin
      bad++; $display("FAIL reset_init_a: count=%0d busy=%b exp=%b err=%b want 0", a_count, a_busy, a_exp, a_err);
    end
    total++;
    if (b_count !== '0 || b_busy !== 1'b0 || b_exp !== 1'b0 || b_err !== 1'b0) begin
      bad++; $display("FAIL reset_init_b: count=%0d busy=%b exp=%b err=%b want 0", b_count, b_busy, b_exp, b_err);
    end
    start_a(10, 1'b0);
    step(); step(); step();
    total++;
    if (a_count !== W'(7) || a_busy !== 1'b1) begin
      bad++; $display("FAIL reset_prerun: count=%0d busy=%b want 7 1", a_count, a_busy);
    end
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    total++;
    if (a_count !== '0 || a_busy !== 1'b0 || a_exp !== 1'b0) begin
      bad++; $display("FAIL reset_midrun: count=%0d busy=%b exp=%b want 0 0 0", a_count, a_busy, a_exp);
    end
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (a_exp === 1'b1 || a_busy === 1'b1) seen++;
      end
      total++;
      if (seen != 0) begin
        bad++; $display("FAIL reset_quiet: active cycles=%0d want 0", seen);
      end
    end
  endtask

  task automatic test_oneshot;
    start_a(5, 1'b0);
    total++;
    if (a_count !== W'(5) || a_busy !== 1'b1 || a_exp !== 1'b0) begin
      bad++; $display("FAIL oneshot_load: count=%0d busy=%b exp=%b want 5 1 0", a_count, a_busy, a_exp);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      total++;
      if (a_count !== W'(5 - k) || a_exp !== (k == 5) || a_busy !== (k < 5)) begin
        bad++; $display("FAIL oneshot_k%0d: count=%0d exp=%b busy=%b want %0d %b %b",
                        k, a_count, a_exp, a_busy, 5 - k, (k == 5), (k < 5));
      end
    end
    step();
    total++;
    if (a_exp !== 1'b0 || a_busy !== 1'b0 || a_count !== '0) begin
      bad++; $display("FAIL oneshot_after: exp=%b busy=%b count=%0d want 0 0 0", a_exp, a_busy, a_count);
    end
  endtask

  task automatic test_periodic_prescale;
    b_start = 1'b1; b_load = W'(3); b_per = 1'b1;
    step();
    b_start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      total++;
      if (b_exp !== (e % 12 == 0) || b_count !== W'(3 - ((e / 4) % 3)) || b_busy !== 1'b1) begin
        bad++; $display("FAIL periodic_e%0d: exp=%b count=%0d busy=%b want %b %0d 1",
                        e, b_exp, b_count, b_busy, (e % 12 == 0), 3 - ((e / 4) % 3));
      end
    end
    b_stop = 1'b1;
    step();
    b_stop = 1'b0;
    total++;
    if (b_busy !== 1'b0 || b_count !== '0 || b_exp !== 1'b0) begin
      bad++; $display("FAIL periodic_stop: busy=%b count=%0d exp=%b want 0 0 0", b_busy, b_count, b_exp);
    end
  endtask

  task automatic test_retrigger_stop;
    start_a(8, 1'b0);
    for (int i = 0; i < 6; i++) step();
    total++;
    if (a_count !== W'(2)) begin
      bad++; $display("FAIL retrig_pre: count=%0d want 2", a_count);
    end
    start_a(4, 1'b0);
    total++;
    if (a_count !== W'(4) || a_exp !== 1'b0 || a_busy !== 1'b1) begin
      bad++; $display("FAIL retrig_load: count=%0d exp=%b busy=%b want 4 0 1", a_count, a_exp, a_busy);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if (a_exp !== (k == 4) || a_count !== W'(4 - k)) begin
        bad++; $display("FAIL retrig_k%0d: exp=%b count=%0d want %b %0d", k, a_exp, a_count, (k == 4), 4 - k);
      end
    end
    start_a(3, 1'b0);
    step(); step();
    total++;
    if (a_count !== W'(1)) begin
      bad++; $display("FAIL stop_pre: count=%0d want 1", a_count);
    end
    a_stop = 1'b1;
    step();
    a_stop = 1'b0;
    total++;
    if (a_exp !== 1'b0 || a_busy !== 1'b0 || a_count !== '0) begin
      bad++; $display("FAIL stop_vs_expiry: exp=%b busy=%b count=%0d want 0 0 0", a_exp, a_busy, a_count);
    end
    step();
    total++;
    if (a_exp !== 1'b0) begin
      bad++; $display("FAIL stop_after: exp=%b want 0", a_exp);
    end
  endtask

  task automatic test_boundaries;
    start_a(0, 1'b1);
    total++;
    if (a_err !== 1'b1 || a_busy !== 1'b0 || a_count !== '0) begin
      bad++; $display("FAIL zero_load: err=%b busy=%b count=%0d want 1 0 0", a_err, a_busy, a_count);
    end
    step();
    total++;
    if (a_err !== 1'b0) begin
      bad++; $display("FAIL zero_err_pulse: err=%b want 0", a_err);
    end
    start_a(1005, 1'b0);
    total++;
    if (a_count !== W'(1000) || a_busy !== 1'b1) begin
      bad++; $display("FAIL clamp: count=%0d busy=%b want 1000 1", a_count, a_busy);
    end
    a_stop = 1'b1;
    step();
    a_stop = 1'b0;
    start_a(1, 1'b0);
    total++;
    if (a_count !== W'(1) || a_busy !== 1'b1 || a_exp !== 1'b0) begin
      bad++; $display("FAIL n1_load: count=%0d busy=%b exp=%b want 1 1 0", a_count, a_busy, a_exp);
    end
    step();
    total++;
    if (a_exp !== 1'b1 || a_busy !== 1'b0 || a_count !== '0) begin
      bad++; $display("FAIL n1_expire: exp=%b busy=%b count=%0d want 1 0 0", a_exp, a_busy, a_count);
    end
  endtask

  task automatic test_start_expiry_collision;
    step();
    start_a(2, 1'b1);
    step();
    total++;
    if (a_count !== W'(1)) begin
      bad++; $display("FAIL coll_pre: count=%0d want 1", a_count);
    end
    start_a(6, 1'b0);
    total++;
    if (a_exp !== 1'b0 || a_count !== W'(6) || a_busy !== 1'b1) begin
      bad++; $display("FAIL coll_start_wins: exp=%b count=%0d busy=%b want 0 6 1", a_exp, a_count, a_busy);
    end
    for (int k = 1; k <= 6; k++) step();
    total++;
    if (a_exp !== 1'b1 || a_busy !== 1'b0 || a_count !== '0) begin
      bad++; $display("FAIL coll_oneshot_mode: exp=%b busy=%b count=%0d want 1 0 0", a_exp, a_busy, a_count);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_prescale();
    test_retrigger_stop();
    test_boundaries();
    test_start_expiry_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
